alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
- Execution unit driven by the multi-cycle controller's alu_en / alu_op / op2_dir strobes.
- Selects operand 2 from rs2 or an immediate decoded from the instruction register, and computes the result.
- Registers the result for the controller's write-back state.
- Single-cycle ops complete at the capture edge. DIV runs an iterative 32-step restoring divider with busy/done handshake, so the controller holds write-back until alu_done.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- DIV_STEPS, 32, divider iterations; must equal XLEN.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_en  in  1  start strobe, sampled on rising clk edge
- alu_op  in  8  ADD=0, ADDI=1, SUB=2, MUL=3, DIV=4, SLL=5, SRL=6, AND=7, OR=8, NOT=9, XOR=10, LUI=11
- op2_dir  in  2  operand-2 source: 00 rs2, 01 U-imm, 10 I-imm, 11 zero
- instr  in  32  current IR contents, for immediates
- rs1_data  in  32  x[rs1]
- rs2_data  in  32  x[rs2]
- alu_result  out  32  registered result; holds until the next completion
- alu_busy  out  1  high while DIV iterates
- alu_done  out  1  one-cycle completion pulse
- alu_dz  out  1  sticky divide-by-zero flag; cleared by the next alu_en accept

Behaviour:
- Reset (async, rst_n=0): alu_result=0, alu_busy=0, alu_done=0, alu_dz=0, state=IDLE, divider regs=0. Reset mid-DIV abandons the operation with no done pulse.
- Immediates:
  - U-imm = {instr[31:12],12'b0}
  - I-imm = sign-extend(instr[31:20])
- op1 = rs1_data; op2 = per op2_dir.
- FSM states: IDLE, DIV_RUN, DIV_FIN.
- IDLE, alu_en=1 at edge E0:
  - Single-cycle ops: alu_result updated at E0; alu_done=1 for the following cycle; alu_busy stays 0.
  - ADD/ADDI: op1+op2, mod 2^32.
  - SUB: op1-op2.
  - MUL: low 32 bits of op1*op2.
  - SLL/SRL: shift by op2[4:0]; SRL is logical.
  - AND/OR/XOR: bitwise on op1, op2.
  - NOT: ~op1.
  - LUI: op2.
  - Unknown alu_op: result 0, done still pulses.
  - DIV, op2==0: single-cycle; result 0xFFFFFFFF, alu_dz=1.
  - DIV, op1==0x80000000 and op2==0xFFFFFFFF: single-cycle; result 0x80000000.
  - Other DIV: capture |op1|, |op2| and the quotient sign (sign1 XOR sign2); alu_busy=1, counter=31, go to DIV_RUN.
- DIV_RUN: one restoring shift-subtract step per edge (E1..E32). At the step with counter==0, go to DIV_FIN.
- DIV_FIN (edge E33): negate the quotient if the sign is set (truncation toward zero), write alu_result, alu_busy=0, alu_done=1 next cycle, return to IDLE.
- alu_en while busy or in DIV_FIN: ignored, no queuing.
- alu_en held high in IDLE: each edge starts a new op, so alu_done may stay high on back-to-back single-cycle ops.
- Inputs (rs1_data, rs2_data, instr) are only needed at E0; the divider works on captured copies.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: MUL and DIV behave as above; alu_busy/alu_dz are functional.
- Undefined: no multiplier or divider hardware. MUL/DIV are treated as unknown ops (result 0, single-cycle done). alu_busy and alu_dz are tied to 0; FSM reduces to IDLE.

Test Plan:
- ADDI, rs1=5, instr[31:20]=0xFFD, op2_dir=10 -> alu_result=0x00000002 right after E0; alu_done high exactly one cycle; alu_busy stays 0.
- LUI, instr[31:12]=0x12345, op2_dir=01 -> alu_result=0x12345000. SRL with rs1=0x80000000, rs2=33 -> 0x40000000 (shift masked to 1).
- DIV, rs1=0xFFFFFFF9 (-7), rs2=2 -> alu_busy high E0..E33; alu_done pulse after E33; result=0xFFFFFFFD (-3). alu_en pulsed at E5 is ignored.
- DIV, rs2=0 -> 0xFFFFFFFF and alu_dz=1 after E0. Next ADD accept clears alu_dz. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, single-cycle.
- Start DIV 100/7, assert rst_n=0 at E10 -> all outputs 0 immediately; no alu_done. Then DIV 100/7 -> 14 after E33.
- Build without ALU_MULDIV_EN: MUL 3*4 -> result 0, done after E0, busy never asserts.

Source files
------------

// File: rtl/alu_unit.sv
// Execution unit: operand-2 select, single-cycle ALU ops and an iterative restoring divider.
// Optional multiplier/divider hardware is built only when ALU_MULDIV_EN is defined.
module alu_unit #(
  parameter int XLEN      = 32,
  parameter int DIV_STEPS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_en,
  input  logic [7:0]      alu_op,
  input  logic [1:0]      op2_dir,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] alu_result,
  output logic            alu_busy,
  output logic            alu_done,
  output logic            alu_dz
);

  localparam logic [7:0] OP_ADD  = 8'd0;
  localparam logic [7:0] OP_ADDI = 8'd1;
  localparam logic [7:0] OP_SUB  = 8'd2;
  localparam logic [7:0] OP_MUL  = 8'd3;
  localparam logic [7:0] OP_DIV  = 8'd4;
  localparam logic [7:0] OP_SLL  = 8'd5;
  localparam logic [7:0] OP_SRL  = 8'd6;
  localparam logic [7:0] OP_AND  = 8'd7;
  localparam logic [7:0] OP_OR   = 8'd8;
  localparam logic [7:0] OP_NOT  = 8'd9;
  localparam logic [7:0] OP_XOR  = 8'd10;
  localparam logic [7:0] OP_LUI  = 8'd11;

  if (XLEN != 32 || DIV_STEPS != XLEN) begin : g_bad_cfg
    $error("alu_unit: only XLEN=32 with DIV_STEPS=XLEN is supported");
  end

  logic [XLEN-1:0] u_imm;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] result_c;

  assign u_imm = {instr[31:12], 12'b0};
  assign i_imm = {{20{instr[31]}}, instr[31:20]};

  always_comb begin
    op2 = '0;
    case (op2_dir)
      2'b00:   op2 = rs2_data;
      2'b01:   op2 = u_imm;
      2'b10:   op2 = i_imm;
      default: op2 = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_FIN} state_t;

  state_t          state;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] rem;
  logic [4:0]      cnt;
  logic            neg;

  logic            div_zero;
  logic            div_ovf;
  logic            div_start;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic [XLEN-1:0] rem_sh;
  logic [XLEN:0]   diff;
  logic            unused_bits;

  assign div_zero  = (op2 == '0);
  assign div_ovf   = (rs1_data == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
  assign div_start = (alu_op == OP_DIV) && !div_zero && !div_ovf;
  assign abs1      = rs1_data[XLEN-1] ? -rs1_data : rs1_data;
  assign abs2      = op2[XLEN-1] ? -op2 : op2;

  // Partial remainder stays below the divisor (<= 2^31), so the shifted value fits in 32 bits.
  assign rem_sh = {rem[XLEN-2:0], quo[XLEN-1]};
  assign diff   = {1'b0, rem_sh} - {1'b0, dvs};

  assign unused_bits = ^{instr[11:0], rem[XLEN-1]};
`else
  logic unused_bits;
  assign unused_bits = ^instr[11:0];
`endif

  always_comb begin
    result_c = '0;
    case (alu_op)
      OP_ADD, OP_ADDI: result_c = rs1_data + op2;
      OP_SUB:          result_c = rs1_data - op2;
      OP_SLL:          result_c = rs1_data << op2[4:0];
      OP_SRL:          result_c = rs1_data >> op2[4:0];
      OP_AND:          result_c = rs1_data & op2;
      OP_OR:           result_c = rs1_data | op2;
      OP_NOT:          result_c = ~rs1_data;
      OP_XOR:          result_c = rs1_data ^ op2;
      OP_LUI:          result_c = op2;
`ifdef ALU_MULDIV_EN
      OP_MUL:          result_c = rs1_data * op2;
      // Only the single-cycle DIV outcomes land here; the overflow quotient equals op1.
      OP_DIV:          result_c = div_zero ? '1 : rs1_data;
`endif
      default:         result_c = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_result <= '0;
      alu_busy   <= 1'b0;
      alu_done   <= 1'b0;
      alu_dz     <= 1'b0;
      quo        <= '0;
      dvs        <= '0;
      rem        <= '0;
      cnt        <= '0;
      neg        <= 1'b0;
    end else begin
      alu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (alu_en) begin
            alu_dz <= (alu_op == OP_DIV) && div_zero;
            if (div_start) begin
              quo      <= abs1;
              dvs      <= abs2;
              rem      <= '0;
              neg      <= rs1_data[XLEN-1] ^ op2[XLEN-1];
              cnt      <= 5'(DIV_STEPS - 1);
              alu_busy <= 1'b1;
              state    <= DIV_RUN;
            end else begin
              alu_result <= result_c;
              alu_done   <= 1'b1;
            end
          end
        end
        DIV_RUN: begin
          quo <= {quo[XLEN-2:0], ~diff[XLEN]};
          rem <= diff[XLEN] ? rem_sh : diff[XLEN-1:0];
          if (cnt == 5'd0) state <= DIV_FIN;
          else             cnt   <= cnt - 5'd1;
        end
        DIV_FIN: begin
          alu_result <= neg ? -quo : quo;
          alu_busy   <= 1'b0;
          alu_done   <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign alu_busy = 1'b0;
  assign alu_dz   = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result <= '0;
      alu_done   <= 1'b0;
    end else begin
      alu_done <= alu_en;
      if (alu_en) alu_result <= result_c;
    end
  end
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: directed cases plus randomized ops checked against a behavioural model.
module tb_alu_unit;

`ifdef ALU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        alu_en;
  logic [7:0]  alu_op;
  logic [1:0]  op2_dir;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] alu_result;
  logic        alu_busy;
  logic        alu_done;
  logic        alu_dz;

  int n_vec = 0;
  int n_err = 0;

  alu_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_en     (alu_en),
    .alu_op     (alu_op),
    .op2_dir    (op2_dir),
    .instr      (instr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .alu_result (alu_result),
    .alu_busy   (alu_busy),
    .alu_done   (alu_done),
    .alu_dz     (alu_dz)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: operand selection and the arithmetic rules stated plainly.
  function automatic void model(input logic [7:0] op, input logic [1:0] dir,
                                input logic [31:0] ir, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] res,
                                output bit dz, output bit multi);
    logic [31:0] o2;
    case (dir)
      2'd0:    o2 = b;
      2'd1:    o2 = {ir[31:12], 12'h000};
      2'd2:    o2 = 32'($signed(ir[31:20]));
      default: o2 = 32'd0;
    endcase
    res = 32'd0;
    dz = 1'b0;
    multi = 1'b0;
    case (op)
      8'd0, 8'd1: res = a + o2;
      8'd2:       res = a - o2;
      8'd3:       if (MULDIV) res = a * o2;
      8'd4: if (MULDIV) begin
        if (o2 == 32'd0) begin
          res = 32'hFFFF_FFFF;
          dz = 1'b1;
        end else if (a == 32'h8000_0000 && o2 == 32'hFFFF_FFFF) begin
          res = 32'h8000_0000;
        end else begin
          res = 32'($signed(a) / $signed(o2));
          multi = 1'b1;
        end
      end
      8'd5:    res = a << o2[4:0];
      8'd6:    res = a >> o2[4:0];
      8'd7:    res = a & o2;
      8'd8:    res = a | o2;
      8'd9:    res = ~a;
      8'd10:   res = a ^ o2;
      8'd11:   res = o2;
      default: res = 32'd0;
    endcase
  endfunction

  // Driver: one accepted op, then wait (bounded) for completion and check it.
  task automatic run_op(input logic [7:0] op, input logic [1:0] dir, input logic [31:0] ir,
                        input logic [31:0] a, input logic [31:0] b, output logic [31:0] got);
    logic [31:0] er;
    bit edz, emulti;
    int lat;
    int exp_lat;
    model(op, dir, ir, a, b, er, edz, emulti);
    exp_lat = emulti ? 33 : 0;
    alu_op = op; op2_dir = dir; instr = ir; rs1_data = a; rs2_data = b; alu_en = 1'b1;
    @(posedge clk); #1;
    alu_en = 1'b0;
    lat = 0;
    while (alu_done !== 1'b1 && lat < 40) begin
      n_vec++;
      if (alu_busy !== 1'b1) begin
        n_err++;
        $display("FAIL busy_while_running op=%0d lat=%0d got=%b required=1", op, lat, alu_busy);
      end
      // Scramble inputs and poke a start at E5: the divider must ignore both.
      alu_en = (lat == 4);
      rs1_data = $urandom; rs2_data = $urandom; instr = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    alu_en = 1'b0;
    n_vec++;
    if (lat != exp_lat) begin
      n_err++;
      $display("FAIL latency op=%0d got=%0d required=%0d", op, lat, exp_lat);
    end
    n_vec++;
    if (alu_done !== 1'b1 || alu_busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_busy op=%0d got done=%b busy=%b required done=1 busy=0",
               op, alu_done, alu_busy);
    end
    n_vec++;
    if (alu_result !== er) begin
      n_err++;
      $display("FAIL result op=%0d dir=%0d a=%h b=%h got=%h required=%h", op, dir, a, b,
               alu_result, er);
    end
    n_vec++;
    if (alu_dz !== edz) begin
      n_err++;
      $display("FAIL dz op=%0d got=%b required=%b", op, alu_dz, edz);
    end
    got = alu_result;
    @(posedge clk); #1;
    n_vec++;
    if (alu_done !== 1'b0 || alu_result !== er) begin
      n_err++;
      $display("FAIL done_pulse_hold op=%0d got done=%b res=%h required done=0 res=%h",
               op, alu_done, alu_result, er);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; alu_en = 1'b0; alu_op = '0; op2_dir = '0;
    instr = '0; rs1_data = '0; rs2_data = '0;
    #12;
    n_vec++;
    if (alu_result !== 32'd0 || alu_busy !== 1'b0 || alu_done !== 1'b0 || alu_dz !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got res=%h busy=%b done=%b dz=%b required all 0",
               alu_result, alu_busy, alu_done, alu_dz);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (alu_done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset got done=%b required 0", alu_done);
    end
  endtask

  task automatic test_directed();
    logic [31:0] got;
    run_op(8'd1, 2'b10, 32'hFFD0_0000, 32'd5, 32'd0, got);
    n_vec++;
    if (got !== 32'h0000_0002) begin
      n_err++; $display("FAIL addi_neg_imm got=%h required=00000002", got);
    end
    run_op(8'd11, 2'b01, 32'h1234_5ABC, 32'hDEAD_BEEF, 32'd0, got);
    n_vec++;
    if (got !== 32'h1234_5000) begin
      n_err++; $display("FAIL lui got=%h required=12345000", got);
    end
    run_op(8'd6, 2'b00, 32'd0, 32'h8000_0000, 32'd33, got);
    n_vec++;
    if (got !== 32'h4000_0000) begin
      n_err++; $display("FAIL srl_masked got=%h required=40000000", got);
    end
    run_op(8'd2, 2'b11, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1111_1111, got);
    n_vec++;
    if (got !== 32'h1234_5678) begin
      n_err++; $display("FAIL sub_zero_op2 got=%h required=12345678", got);
    end
    run_op(8'd200, 2'b00, 32'd0, 32'hFFFF_FFFF, 32'h1, got);
    n_vec++;
    if (got !== 32'd0) begin
      n_err++; $display("FAIL unknown_op got=%h required=00000000", got);
    end
  endtask

`ifdef ALU_MULDIV_EN
  task automatic test_div_directed();
    logic [31:0] got;
    run_op(8'd4, 2'b00, 32'd0, 32'hFFFF_FFF9, 32'd2, got);
    n_vec++;
    if (got !== 32'hFFFF_FFFD) begin
      n_err++; $display("FAIL div_neg7_by_2 got=%h required=fffffffd", got);
    end
    run_op(8'd4, 2'b00, 32'd0, 32'd77, 32'd0, got);
    n_vec++;
    if (got !== 32'hFFFF_FFFF || alu_dz !== 1'b1) begin
      n_err++; $display("FAIL div_by_zero got res=%h dz=%b required ffffffff dz=1", got, alu_dz);
    end
    run_op(8'd0, 2'b00, 32'd0, 32'd1, 32'd2, got);
    n_vec++;
    if (alu_dz !== 1'b0) begin
      n_err++; $display("FAIL dz_clear_on_accept got=%b required 0", alu_dz);
    end
    run_op(8'd4, 2'b00, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, got);
    n_vec++;
    if (got !== 32'h8000_0000) begin
      n_err++; $display("FAIL div_overflow got=%h required=80000000", got);
    end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] got;
    alu_op = 8'd4; op2_dir = 2'b00; rs1_data = 32'd100; rs2_data = 32'd7; alu_en = 1'b1;
    @(posedge clk); #1;
    alu_en = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    n_vec++;
    if (alu_busy !== 1'b1) begin
      n_err++; $display("FAIL busy_before_reset got=%b required 1", alu_busy);
    end
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (alu_result !== 32'd0 || alu_busy !== 1'b0 || alu_done !== 1'b0 || alu_dz !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_div got res=%h busy=%b done=%b dz=%b required all 0",
               alu_result, alu_busy, alu_done, alu_dz);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      n_vec++;
      if (alu_done !== 1'b0 || alu_busy !== 1'b0) begin
        n_err++;
        $display("FAIL abandoned_div got done=%b busy=%b required 0 0", alu_done, alu_busy);
      end
    end
    run_op(8'd4, 2'b00, 32'd0, 32'd100, 32'd7, got);
    n_vec++;
    if (got !== 32'd14) begin
      n_err++; $display("FAIL div_after_reset got=%h required=0000000e", got);
    end
  endtask
`else
  task automatic test_no_muldiv();
    logic [31:0] got;
    run_op(8'd3, 2'b00, 32'd0, 32'd3, 32'd4, got);
    n_vec++;
    if (got !== 32'd0 || alu_busy !== 1'b0) begin
      n_err++; $display("FAIL mul_disabled got res=%h busy=%b required 0 0", got, alu_busy);
    end
    run_op(8'd4, 2'b00, 32'd0, 32'd9, 32'd0, got);
    n_vec++;
    if (got !== 32'd0 || alu_dz !== 1'b0) begin
      n_err++; $display("FAIL div_disabled got res=%h dz=%b required 0 0", got, alu_dz);
    end
  endtask
`endif

  task automatic test_random(input int n);
    logic [31:0] got, a, b, ir;
    logic [7:0] op;
    logic [1:0] dir;
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 15);
      op = (r == 15) ? 8'($urandom_range(12, 255)) : 8'(r);
      dir = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom; ir = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 40));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; dir = 2'b00; end
        3: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op(op, dir, ir, a, b, got);
    end
  endtask

  task automatic test_back_to_back(input int n);
    logic [31:0] er, a, b, ir;
    logic [7:0] op;
    logic [1:0] dir;
    bit edz, emulti;
    for (int i = 0; i < n; i++) begin
      do op = 8'($urandom_range(0, 13)); while (op == 8'd4);
      dir = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom; ir = $urandom;
      model(op, dir, ir, a, b, er, edz, emulti);
      alu_op = op; op2_dir = dir; instr = ir; rs1_data = a; rs2_data = b; alu_en = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (alu_done !== 1'b1 || alu_result !== er || alu_dz !== 1'b0) begin
        n_err++;
        $display("FAIL back_to_back op=%0d got done=%b res=%h dz=%b required 1 %h 0",
                 op, alu_done, alu_result, alu_dz, er);
      end
    end
    alu_en = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (alu_done !== 1'b0) begin
      n_err++; $display("FAIL back_to_back_end got done=%b required 0", alu_done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
`ifdef ALU_MULDIV_EN
    test_div_directed();
    test_reset_mid_div();
`else
    test_no_muldiv();
`endif
    test_back_to_back(24);
    test_random(200);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
